mram_burst_serial_ctrl: RTL and testbench
=========================================

# mram_burst_serial_ctrl

Parametrised serial-to-MRAM burst controller, successor to the single-word serial MRAM front end. It accepts a serial command frame (op, byte select, burst length, start address) plus optional write payload. It then performs a burst of consecutive asynchronous MRAM accesses with auto-incrementing address and returns read data serially. It sits between the FPGA-side serial link and the MRAM pins.

## Interface
- DATA_W, 16: MRAM data bus width; must be at least 9, since lane split is [7:0] / [DATA_W-1:8].
- ADDR_W, 20: MRAM address width.
- LEN_W, 4: burst-length field width; a burst is 1..2^LEN_W words.
- WAIT_CYC, 2: cycles write_en_n / out_en_n are held low per access; must be at least 1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  single-cycle pulse that opens a frame; ignored while busy=1.
- ser_in  in  1  serial frame bit, MSB first.
- ser_in_valid  in  1  qualifies ser_in; low = stall, no bit consumed.
- ser_out  out  1  serial read data, MSB first.
- ser_out_valid  out  1  qualifies ser_out.
- busy  out  1  high from accepted cmd_start until return to IDLE.
- done  out  1  one-cycle pulse when the burst completes.
- err  out  1  sticky overrun flag; cleared by the next accepted cmd_start.
- addr_out  out  ADDR_W  MRAM address.
- data_out  inout  DATA_W  MRAM DQ bus; high-Z unless writing.
- chip_en_n, write_en_n, out_en_n, lower_byte_en_n, upper_byte_en_n  out  1 each  MRAM strobes, active low.

## Operation
- Header: HDR_W = 3+LEN_W+ADDR_W bits, 27 by default. Field order, MSB first:
  - op: 0 = read, 1 = write.
  - bsel[1:0]: 00 = full word, 01 = lower byte, 10 = upper byte, 11 = full word.
  - len_m1: burst length minus 1.
  - start address.
- States: IDLE, HDR, WDATA, WSETUP, WPULSE, WHOLD, RPULSE, RSHIFT.
- IDLE: on cmd_start, go to HDR, clear err and the bit counter, set busy.
- HDR: shift in HDR_W valid bits. Then:
  - op=1 goes to WDATA.
  - op=0 goes to RPULSE.
  - addr_out loads the start address; the word counter loads len_m1.
- WDATA: shift in DATA_W valid bits, then go to WSETUP.
- WSETUP, 1 cycle: chip_en_n=0, data_out driven, byte enables asserted per bsel, write_en_n=1.
- WPULSE, WAIT_CYC cycles: write_en_n=0, everything else as in WSETUP.
- WHOLD, 1 cycle: write_en_n=1, data_out still driven, chip_en_n=0. Then:
  - Word counter = 0: go to IDLE and pulse done.
  - Otherwise: decrement the word counter, increment addr_out, go to WDATA.
- RPULSE, WAIT_CYC cycles: chip_en_n=0, out_en_n=0, byte enables per bsel. data_out is captured on the last cycle's edge; disabled lanes are captured as 0.
- RSHIFT, DATA_W cycles: ser_out_valid=1, capture register shifted MSB first. Then take the same counter/address branch as WHOLD, returning to RPULSE or IDLE/done.
- Address: increments modulo 2^ADDR_W, so all-ones wraps to 0.
- Overrun: ser_in_valid=1 in any state other than HDR/WDATA sets err. The bit is dropped and the burst continues.
- All strobes are high in IDLE, HDR and WDATA.

## Timing
- Reset values (applied immediately, asynchronously):
  - state = IDLE.
  - all *_n strobes = 1.
  - data_out = Z.
  - ser_out = 0, ser_out_valid = 0, busy = 0, done = 0, err = 0.
  - addr_out = 0.
- Reset mid-burst aborts with no completion pulse.
- busy rises the cycle after cmd_start is sampled.
- The first header bit may be presented in that same cycle.
- Write word cost: DATA_W valid-bit cycles + WAIT_CYC + 2.
- Read word cost: WAIT_CYC + DATA_W.
- First ser_out_valid is the cycle after the last RPULSE cycle.
- done is high for exactly one cycle, coincident with the transition into IDLE; busy falls on that same edge.
- A cmd_start coincident with done is ignored.
- Any cmd_start while busy is ignored and does not set err.
- data_out is driven only in WSETUP, WPULSE and WHOLD. It is never driven while out_en_n=0.

## Test plan
- Reset with rst held mid-WPULSE:
  - strobes go to 1 and data_out to Z within the same cycle;
  - after release, busy=0 and addr_out=0.
- Single full-word write, addr 0x00010, data 0xA5C3:
  - one 2-cycle write_en_n low pulse with DQ=0xA5C3 and both byte enables low;
  - done 1 cycle later.
- Burst read, len_m1=2, addr 0x00100, model returns 0x1111/0x2222/0x3333:
  - 48 ser_out_valid bits matching, MSB first;
  - addr_out steps 0x100, 0x101, 0x102.
- Lower-byte read of 0xBEEF:
  - upper_byte_en_n=1, lower_byte_en_n=0;
  - serial word shifted out is 0x00EF.
- Wrap: write burst len_m1=1 at addr 0xFFFFF; accesses hit 0xFFFFF then 0x00000.
- Stall/overrun: toggle ser_in_valid low for random gaps during HDR/WDATA, then assert it during RSHIFT:
  - payload is assembled correctly;
  - err=1 until the next cmd_start.

Source files
------------

// File: rtl/mram_burst_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mram_burst_serial_ctrl                                                     |
// | Serial command frame in, burst of asynchronous MRAM accesses out, with     |
// | auto-incrementing address and serial read-data return.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mram_burst_serial_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 20,
  parameter int LEN_W    = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              ser_in,
  input  logic              ser_in_valid,
  output logic              ser_out,
  output logic              ser_out_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addr_out,
  inout  wire  [DATA_W-1:0] data_out,
  output logic              chip_en_n,
  output logic              write_en_n,
  output logic              out_en_n,
  output logic              lower_byte_en_n,
  output logic              upper_byte_en_n
);

  localparam int HDR_W   = 3 + LEN_W + ADDR_W;
  localparam int CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int WAIT_W  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_WDATA  = 3'd2,
    S_WSETUP = 3'd3,
    S_WPULSE = 3'd4,
    S_WHOLD  = 3'd5,
    S_RPULSE = 3'd6,
    S_RSHIFT = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [HDR_W-2:0]    hdr_sr_q, hdr_sr_d;
  logic [DATA_W-1:0]   data_sr_q, data_sr_d;
  logic [1:0]          bsel_q, bsel_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [HDR_W-1:0]    w_hdr;
  logic                w_lower_en;
  logic                w_upper_en;
  logic [DATA_W-1:0]   w_lane_mask;
  logic                w_drive;

  assign w_hdr       = {hdr_sr_q, ser_in};
  assign w_lower_en  = (bsel_q != 2'b10);
  assign w_upper_en  = (bsel_q != 2'b01);
  assign w_lane_mask = {{(DATA_W-8){w_upper_en}}, {8{w_lower_en}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      hdr_sr_q   <= '0;
      data_sr_q  <= '0;
      bsel_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      hdr_sr_q   <= hdr_sr_d;
      data_sr_q  <= data_sr_d;
      bsel_q     <= bsel_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    hdr_sr_d   = hdr_sr_q;
    data_sr_d  = data_sr_q;
    bsel_d     = bsel_q;
    done_d     = 1'b0;
    err_d      = err_q;

    // A bit offered while no frame field is being shifted is lost.
    if (ser_in_valid && (state_q != S_HDR) && (state_q != S_WDATA)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // done_q high means the burst just ended; that cycle's start is ignored.
        if (cmd_start && !done_q) begin
          state_d   = S_HDR;
          bit_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      S_HDR: begin
        if (ser_in_valid) begin
          hdr_sr_d  = w_hdr[HDR_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(HDR_W-1)) begin
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            bsel_d     = w_hdr[HDR_W-2 -: 2];
            word_cnt_d = w_hdr[ADDR_W +: LEN_W];
            addr_d     = w_hdr[ADDR_W-1:0];
            state_d    = w_hdr[HDR_W-1] ? S_WDATA : S_RPULSE;
          end
        end
      end
      S_WDATA: begin
        if (ser_in_valid) begin
          data_sr_d = {data_sr_q[DATA_W-2:0], ser_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            bit_cnt_d = '0;
            state_d   = S_WSETUP;
          end
        end
      end
      S_WSETUP: begin
        wait_cnt_d = '0;
        state_d    = S_WPULSE;
      end
      S_WPULSE: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_W'(WAIT_CYC-1)) begin
          wait_cnt_d = '0;
          state_d    = S_WHOLD;
        end
      end
      S_WHOLD: begin
        if (word_cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q - 1'b1;
          addr_d     = addr_q + 1'b1;
          bit_cnt_d  = '0;
          state_d    = S_WDATA;
        end
      end
      S_RPULSE: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_W'(WAIT_CYC-1)) begin
          wait_cnt_d = '0;
          bit_cnt_d  = '0;
          data_sr_d  = data_out & w_lane_mask;
          state_d    = S_RSHIFT;
        end
      end
      S_RSHIFT: begin
        data_sr_d = {data_sr_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          if (word_cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q - 1'b1;
            addr_d     = addr_q + 1'b1;
            state_d    = S_RPULSE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    chip_en_n       = 1'b1;
    write_en_n      = 1'b1;
    out_en_n        = 1'b1;
    lower_byte_en_n = 1'b1;
    upper_byte_en_n = 1'b1;
    w_drive         = 1'b0;
    case (state_q)
      S_WSETUP, S_WPULSE, S_WHOLD: begin
        chip_en_n       = 1'b0;
        write_en_n      = (state_q != S_WPULSE);
        lower_byte_en_n = !w_lower_en;
        upper_byte_en_n = !w_upper_en;
        w_drive         = 1'b1;
      end
      S_RPULSE: begin
        chip_en_n       = 1'b0;
        out_en_n        = 1'b0;
        lower_byte_en_n = !w_lower_en;
        upper_byte_en_n = !w_upper_en;
      end
      default: ;
    endcase
  end

  assign data_out      = w_drive ? data_sr_q : {DATA_W{1'bz}};
  assign ser_out_valid = (state_q == S_RSHIFT);
  assign ser_out       = (state_q == S_RSHIFT) && data_sr_q[DATA_W-1];
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign addr_out      = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mram_burst_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mram_burst_serial_ctrl                                                  |
// | Directed bench for the serial MRAM burst controller with a small MRAM.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mram_burst_serial_ctrl;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 20;
  localparam int LEN_W    = 4;
  localparam int WAIT_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic        ser_in;
  logic        ser_in_valid;
  logic        ser_out;
  logic        ser_out_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [19:0] addr_out;
  wire  [15:0] dq;
  logic        chip_en_n;
  logic        write_en_n;
  logic        out_en_n;
  logic        lower_byte_en_n;
  logic        upper_byte_en_n;

  mram_burst_serial_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_start      (cmd_start),
    .ser_in         (ser_in),
    .ser_in_valid   (ser_in_valid),
    .ser_out        (ser_out),
    .ser_out_valid  (ser_out_valid),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .addr_out       (addr_out),
    .data_out       (dq),
    .chip_en_n      (chip_en_n),
    .write_en_n     (write_en_n),
    .out_en_n       (out_en_n),
    .lower_byte_en_n(lower_byte_en_n),
    .upper_byte_en_n(upper_byte_en_n)
  );

  always #5 clk = ~clk;

  // Small MRAM: 1K words, aliased on the low address bits.
  logic [15:0] mem [0:1023];
  assign dq = (!chip_en_n && !out_en_n) ? mem[addr_out[9:0]] : 16'hzzzz;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          done_dbl = 0;
  int          we_cycles = 0;
  int          we_pulses = 0;
  logic        prev_we = 1'b1;
  logic        prev_oe = 1'b1;
  logic        prev_done = 1'b0;
  logic [19:0] w_addr_log [$];
  logic [15:0] w_data_log [$];
  logic [1:0]  w_be_log [$];
  logic [19:0] r_addr_log [$];
  logic [1:0]  r_be_log [$];
  logic        ser_bits [$];

  always @(negedge clk) begin
    if (!write_en_n) begin
      we_cycles <= we_cycles + 1;
      if (!lower_byte_en_n) mem[addr_out[9:0]][7:0]  <= dq[7:0];
      if (!upper_byte_en_n) mem[addr_out[9:0]][15:8] <= dq[15:8];
      if (prev_we) begin
        we_pulses <= we_pulses + 1;
        w_addr_log.push_back(addr_out);
        w_data_log.push_back(dq);
        w_be_log.push_back({upper_byte_en_n, lower_byte_en_n});
      end
    end
    if (!out_en_n && prev_oe) begin
      r_addr_log.push_back(addr_out);
      r_be_log.push_back({upper_byte_en_n, lower_byte_en_n});
    end
    if (ser_out_valid) ser_bits.push_back(ser_out);
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (prev_done) done_dbl <= done_dbl + 1;
    end
    prev_we   <= write_en_n;
    prev_oe   <= out_en_n;
    prev_done <= done;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    w_addr_log.delete();
    w_data_log.delete();
    w_be_log.delete();
    r_addr_log.delete();
    r_be_log.delete();
    ser_bits.delete();
  endtask

  task automatic send_bits(input logic [63:0] val, input int nbits, input bit stall);
    int gap;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (stall) begin
        gap = $urandom_range(0, 3);
        ser_in_valid = 1'b0;
        repeat (gap) tick();
      end
      ser_in       = val[i];
      ser_in_valid = 1'b1;
      tick();
    end
    ser_in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic op, input logic [1:0] bsel, input logic [3:0] len_m1,
                             input logic [19:0] addr, input bit stall);
    logic [26:0] h;
    h = {op, bsel, len_m1, addr};
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    send_bits(64'(h), 27, stall);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(done), 64'(1));
  endtask

  function automatic logic [63:0] ser_value();
    logic [63:0] v;
    v = '0;
    foreach (ser_bits[k]) v = {v[62:0], ser_bits[k]};
    return v;
  endfunction

  int n;
  int done_before;

  initial begin
    rst          = 1'b1;
    cmd_start    = 1'b0;
    ser_in       = 1'b0;
    ser_in_valid = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h100] = 16'h1111;
    mem[10'h101] = 16'h2222;
    mem[10'h102] = 16'h3333;
    mem[10'h200] = 16'hBEEF;

    // Reset state
    repeat (2) tick();
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done_err", 64'({done, err}), 64'(0));
    check_eq("rst_ser_out", 64'({ser_out_valid, ser_out}), 64'(0));
    check_eq("rst_addr", 64'(addr_out), 64'(0));
    check_eq("rst_strobes", 64'({chip_en_n, write_en_n, out_en_n, lower_byte_en_n, upper_byte_en_n}),
             64'(5'b11111));
    rst = 1'b0;
    tick();

    // Single full-word write of 0xA5C3 at 0x00010
    clear_logs();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check_eq("busy_rise", 64'(busy), 64'(1));
    send_bits(64'({1'b1, 2'b00, 4'd0, 20'h00010}), 27, 1'b0);
    send_bits(64'(16'hA5C3), 16, 1'b0);
    wait_done("wr1_done", n);
    check_eq("wr1_latency", 64'(n), 64'(4));
    check_eq("wr1_busy_fall", 64'(busy), 64'(0));
    // cmd_start coincident with done is ignored
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check_eq("wr1_done_single", 64'(done), 64'(0));
    check_eq("start_on_done_ignored", 64'(busy), 64'(0));
    check_eq("wr1_we_cycles", 64'(we_cycles), 64'(2));
    check_eq("wr1_we_pulses", 64'(we_pulses), 64'(1));
    check_eq("wr1_addr", 64'(w_addr_log[0]), 64'(20'h00010));
    check_eq("wr1_dq", 64'(w_data_log[0]), 64'(16'hA5C3));
    check_eq("wr1_be", 64'(w_be_log[0]), 64'(2'b00));

    // Burst read of three words at 0x100
    tick();
    clear_logs();
    start_frame(1'b0, 2'b00, 4'd2, 20'h00100, 1'b0);
    wait_done("rd3_done", n);
    tick();
    check_eq("rd3_bit_count", 64'(ser_bits.size()), 64'(48));
    check_eq("rd3_data", ser_value(), 64'h0000_1111_2222_3333);
    check_eq("rd3_n_access", 64'(r_addr_log.size()), 64'(3));
    check_eq("rd3_addr0", 64'(r_addr_log[0]), 64'(20'h00100));
    check_eq("rd3_addr1", 64'(r_addr_log[1]), 64'(20'h00101));
    check_eq("rd3_addr2", 64'(r_addr_log[2]), 64'(20'h00102));
    check_eq("rd3_err", 64'(err), 64'(0));

    // Lower-byte read of 0xBEEF
    clear_logs();
    start_frame(1'b0, 2'b01, 4'd0, 20'h00200, 1'b0);
    wait_done("rdlo_done", n);
    tick();
    check_eq("rdlo_be", 64'(r_be_log[0]), 64'(2'b10));
    check_eq("rdlo_data", ser_value(), 64'(16'h00EF));

    // Address wrap on a two-word write burst from 0xFFFFF
    clear_logs();
    start_frame(1'b1, 2'b00, 4'd1, 20'hFFFFF, 1'b0);
    send_bits(64'(16'h1234), 16, 1'b0);
    repeat (WAIT_CYC + 2) tick();
    send_bits(64'(16'h5678), 16, 1'b0);
    wait_done("wrap_done", n);
    tick();
    check_eq("wrap_n_access", 64'(w_addr_log.size()), 64'(2));
    check_eq("wrap_addr0", 64'(w_addr_log[0]), 64'(20'hFFFFF));
    check_eq("wrap_addr1", 64'(w_addr_log[1]), 64'(20'h00000));
    check_eq("wrap_mem_top", 64'(mem[10'h3FF]), 64'(16'h1234));
    check_eq("wrap_mem_zero", 64'(mem[10'h000]), 64'(16'h5678));

    // Stalled frames, then an overrun during RSHIFT
    clear_logs();
    start_frame(1'b1, 2'b00, 4'd0, 20'h00300, 1'b1);
    send_bits(64'(16'h9F6B), 16, 1'b1);
    wait_done("stall_wr_done", n);
    tick();
    check_eq("stall_wr_dq", 64'(w_data_log[0]), 64'(16'h9F6B));
    check_eq("stall_wr_err", 64'(err), 64'(0));
    clear_logs();
    start_frame(1'b0, 2'b00, 4'd0, 20'h00300, 1'b1);
    n = 0;
    while (!ser_out_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("ovr_reach_rshift", 64'(ser_out_valid), 64'(1));
    ser_in_valid = 1'b1;
    tick();
    ser_in_valid = 1'b0;
    wait_done("ovr_done", n);
    tick();
    check_eq("ovr_data", ser_value(), 64'(16'h9F6B));
    check_eq("ovr_err_set", 64'(err), 64'(1));
    repeat (3) tick();
    check_eq("ovr_err_sticky", 64'(err), 64'(1));

    // Next frame clears err; reset is applied in the middle of its write pulse
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check_eq("err_cleared", 64'(err), 64'(0));
    send_bits(64'({1'b1, 2'b00, 4'd0, 20'h00040}), 27, 1'b0);
    send_bits(64'(16'h0F0F), 16, 1'b0);
    n = 0;
    while (write_en_n && n < 10) begin
      tick();
      n++;
    end
    check_eq("rst_mid_in_wpulse", 64'(write_en_n), 64'(0));
    done_before = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_strobes", 64'({chip_en_n, write_en_n, out_en_n, lower_byte_en_n, upper_byte_en_n}),
             64'(5'b11111));
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_mid_busy", 64'(busy), 64'(0));
    check_eq("rst_mid_addr", 64'(addr_out), 64'(0));
    check_eq("rst_mid_no_done", 64'(done_cnt), 64'(done_before));
    check_eq("done_never_double", 64'(done_dbl), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
